file_responder: RTL and testbench
=================================

// Module: file_responder
// PURPOSE
//  Responder end of the byte-serial file protocol used by the PE stages: decodes a header byte
//  'R'(0x52) or 'W'(0x57) plus a 2-byte file index, then streams the file's bytes out ('R') or
//  absorbs them into backing RAM ('W'). Sits behind the responder-side rs232 instance; file
//  placement comes from an external file table (index -> base, length, valid).
// PARAMETERS
//  ADDR_W      16     backing-RAM address width
//  DATA_W      8      byte width (protocol is byte-oriented; fixed at 8)
//  LEN_W       16     file length width
//  TIMEOUT_CYC 65535  inter-byte idle limit in clk cycles (used only with RESP_TIMEOUT_EN)
// PORTS
//  clk        in   1       system clock
//  reset      in   1       asynchronous, active-high reset
//  rx_data    in   8       received byte from rs232
//  rx_rdy     in   1       1-cycle strobe: rx_data valid
//  tx_data    out  8       byte to transmit
//  tx_en      out  1       1-cycle strobe: send tx_data
//  tx_busy    in   1       transmitter busy
//  file_idx   out  16      index presented to file table ({hi,lo} as received)
//  file_base  in   ADDR_W  table: first RAM address of file
//  file_len   in   LEN_W   table: byte count of file
//  file_ok    in   1       table: index is defined
//  mem_addr   out  ADDR_W  backing-RAM address
//  mem_rdata  in   8       RAM read data, valid 1 cycle after mem_addr (sync read)
//  mem_wdata  out  8       RAM write data
//  mem_we     out  1       RAM write enable (1 cycle per byte)
//  busy       out  1       high from accepted header until return to IDLE
//  done       out  1       1-cycle pulse: transfer completed
//  err        out  1       1-cycle pulse: bad header, undefined file, or timeout
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; internal counters 0. Reset mid-transfer aborts, no done/err.
//  States: IDLE -> IDX_HI -> IDX_LO -> LOOKUP -> {RD_FETCH, RD_SEND, RD_WAIT | WR_RECV} -> IDLE.
//  IDLE: on rx_rdy, 0x52 -> IDX_HI (mode=R), 0x57 -> IDX_HI (mode=W); other bytes -> err pulse, stay.
//  IDX_HI/IDX_LO: on rx_rdy latch index high then low byte; file_idx driven from these registers.
//  LOOKUP (1 cycle): latch base/len. file_ok=0 -> err pulse, IDLE. len=0 -> done pulse, IDLE.
//  RD_FETCH: mem_addr=base+cnt; next cycle RD_SEND. RD_SEND: when !tx_busy, tx_data=mem_rdata,
//   tx_en=1 for 1 cycle, cnt++ -> RD_WAIT. RD_WAIT: ignore tx_busy 1 cycle, then wait !tx_busy;
//   cnt==len -> done, IDLE; else RD_FETCH. Bytes sent in ascending address order.
//  WR_RECV: each rx_rdy -> mem_addr=base+cnt, mem_wdata=rx_data, mem_we=1 same cycle, cnt++;
//   after byte len-1 written, done pulse next cycle, IDLE.
//  Half-duplex: rx_rdy ignored in read states; tx_en never asserted outside RD_SEND.
//  Address arithmetic modulo 2^ADDR_W (wraps, no error). cnt width LEN_W.
//  rx_rdy in same cycle as done: byte treated as next header (IDLE decodes that cycle).
//  Undefined index on W: remaining initiator bytes are parsed as headers (documented limitation).
// CONFIGURATION
//  RESP_TIMEOUT_EN defined: in IDX_HI, IDX_LO, WR_RECV an idle counter counts cycles since last
//   rx_rdy; reaching TIMEOUT_CYC -> err pulse, IDLE, no further mem_we. Counter clears on rx_rdy.
//  Not defined: no counter logic; those states wait indefinitely.
// TESTING
//  Reset, then 'R',0x00,0x01 with table base=784,len=25 -> 25 tx_en pulses carrying mem[784..808]
//   in order, each only while tx_busy=0, then single done pulse, busy 0.
//  'W',0x09,0x61 base=809,len=49, 49 bytes 0x00..0x30 -> mem[809+k]=k, 49 mem_we pulses, done.
//  Header 0x41 -> err pulse, no state change; then valid 'R' transfer completes normally.
//  file_ok=0 for index 0x0FFF -> err pulse after IDX_LO, no tx_en, no mem_we; len=0 -> done only.
//  Assert reset after 10 of 25 read bytes -> all outputs 0 immediately; new 'R' restarts at base.
//  RESP_TIMEOUT_EN, TIMEOUT_CYC=100: 'W' index, 3 bytes, then silence -> err at 100 idle cycles.

Source files
------------

// File: rtl/file_responder.sv
// Responder end of the byte-serial file protocol: 'R'/'W' header, 2-byte index, byte stream.
// Optional inter-byte idle timeout is enabled by defining RESP_TIMEOUT_EN.
module file_responder #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int LEN_W       = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_rdy,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_en,
    input  logic              tx_busy,
    output logic [15:0]       file_idx,
    input  logic [ADDR_W-1:0] file_base,
    input  logic [LEN_W-1:0]  file_len,
    input  logic              file_ok,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE, IDX_HI, IDX_LO, LOOKUP,
        RD_FETCH, RD_SEND, RD_WAIT, WR_RECV
    } state_t;

    localparam logic [DATA_W-1:0] HDR_R = DATA_W'(8'h52);
    localparam logic [DATA_W-1:0] HDR_W = DATA_W'(8'h57);

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [DATA_W-1:0]  idx_hi_q, idx_lo_q;
    logic [ADDR_W-1:0]  base_q;
    logic [LEN_W-1:0]   len_q, cnt_q;
    logic               hold_q;
    logic               lat_hi, lat_lo, lat_tab;
    logic               cnt_inc, set_done, set_err;
    logic               timeout;

    assign file_idx  = {idx_hi_q, idx_lo_q};
    assign mem_addr  = base_q + ADDR_W'(cnt_q);
    assign busy      = (state_q != IDLE);
    assign tx_data   = (state_q == RD_SEND) ? mem_rdata : '0;
    assign mem_wdata = (state_q == WR_RECV) ? rx_data : '0;

`ifdef RESP_TIMEOUT_EN
    logic        wait_st;
    logic [31:0] idle_q;

    assign wait_st = state_q inside {IDX_HI, IDX_LO, WR_RECV};
    assign timeout = wait_st && !rx_rdy &&
                     (idle_q == 32'(TIMEOUT_CYC - 1));

    // Count idle cycles while waiting on the initiator
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idle_q <= '0;
        else if (!wait_st || rx_rdy || timeout)
            idle_q <= '0;
        else
            idle_q <= idle_q + 32'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        tx_en    = 1'b0;
        mem_we   = 1'b0;
        lat_hi   = 1'b0;
        lat_lo   = 1'b0;
        lat_tab  = 1'b0;
        cnt_inc  = 1'b0;
        set_done = 1'b0;
        set_err  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_rdy) begin
                    if (rx_data == HDR_R) begin
                        mode_d  = 1'b0;
                        state_d = IDX_HI;
                    end else if (rx_data == HDR_W) begin
                        mode_d  = 1'b1;
                        state_d = IDX_HI;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            IDX_HI: begin
                if (rx_rdy) begin
                    lat_hi  = 1'b1;
                    state_d = IDX_LO;
                end
            end
            IDX_LO: begin
                if (rx_rdy) begin
                    lat_lo  = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                lat_tab = 1'b1;
                if (!file_ok) begin
                    set_err = 1'b1;
                    state_d = IDLE;
                end else if (file_len == '0) begin
                    set_done = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = mode_q ? WR_RECV : RD_FETCH;
                end
            end
            RD_FETCH: state_d = RD_SEND;
            RD_SEND: begin
                if (!tx_busy) begin
                    tx_en   = 1'b1;
                    cnt_inc = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (!hold_q && !tx_busy) begin
                    if (cnt_q == len_q) begin
                        set_done = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = RD_FETCH;
                    end
                end
            end
            WR_RECV: begin
                if (rx_rdy) begin
                    mem_we  = 1'b1;
                    cnt_inc = 1'b1;
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        set_done = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            set_err = 1'b1;
            state_d = IDLE;
        end
    end

    // Index, file placement, byte counter and status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_hi_q <= '0;
            idx_lo_q <= '0;
            base_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            hold_q   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            hold_q <= tx_en;
            done   <= set_done;
            err    <= set_err;
            if (lat_hi)
                idx_hi_q <= rx_data;
            if (lat_lo)
                idx_lo_q <= rx_data;
            if (lat_tab) begin
                base_q <= file_base;
                len_q  <= file_len;
                cnt_q  <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_file_responder.sv
// Bench for file_responder: directed vector table, hand sequences and random transfers
// checked against a byte-level model of the file table and backing RAM.
module tb_file_responder;

    logic        clk, reset;
    logic [7:0]  rx_data, tx_data, mem_rdata, mem_wdata;
    logic        rx_rdy, tx_en, tx_busy, file_ok, mem_we;
    logic        busy, done, err;
    logic [15:0] file_idx, file_base, file_len, mem_addr;

    file_responder #(.TIMEOUT_CYC(100)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_rdy(rx_rdy),
        .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
        .file_idx(file_idx), .file_base(file_base),
        .file_len(file_len), .file_ok(file_ok),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .mem_we(mem_we),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // file table
    logic [15:0] tbl_idx  [12];
    logic [15:0] tbl_base [12];
    logic [15:0] tbl_len  [12];
    logic        tbl_ok   [12];

    always_comb begin
        file_ok   = 1'b0;
        file_base = '0;
        file_len  = '0;
        for (int i = 0; i < 12; i++) begin
            if (tbl_idx[i] == file_idx) begin
                file_ok   = tbl_ok[i];
                file_base = tbl_base[i];
                file_len  = tbl_len[i];
            end
        end
    end

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // backing RAM, synchronous read
    logic [7:0] ram [logic [15:0]];
    always @(posedge clk) begin
        mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : init_byte(mem_addr);
        if (mem_we)
            ram[mem_addr] = mem_wdata;
    end

    // transmitter: busy for a few cycles after each send, plus random stalls
    logic [2:0] bcnt;
    logic       stall;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt  <= '0;
            stall <= 1'b0;
        end else begin
            if (tx_en)
                bcnt <= 3'($urandom_range(1, 6));
            else if (bcnt != 0)
                bcnt <= bcnt - 3'd1;
            stall <= ($urandom_range(0, 3) == 0);
        end
    end
    assign tx_busy = (bcnt != 0) || stall;

    // output monitor
    logic [7:0]  tx_q [$];
    logic [15:0] wa_q [$];
    logic [7:0]  wd_q [$];
    int n_done = 0;
    int n_err = 0;
    int busy_viol = 0;
    always @(negedge clk) begin
        if (tx_en) begin
            tx_q.push_back(tx_data);
            if (tx_busy)
                busy_viol++;
        end
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
        if (done)
            n_done++;
        if (err)
            n_err++;
    end

    // reference model of RAM contents
    logic [7:0] exp_mem [logic [15:0]];

    function automatic logic [7:0] model_rd(input logic [15:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : init_byte(a);
    endfunction

    task automatic model_lookup(input logic [15:0] idx, output logic ok,
                                output logic [15:0] base, output logic [15:0] len);
        ok = 1'b0;
        base = '0;
        len = '0;
        for (int i = 0; i < 12; i++) begin
            if (tbl_idx[i] == idx) begin
                ok = tbl_ok[i];
                base = tbl_base[i];
                len = tbl_len[i];
            end
        end
    endtask

    task automatic model_expect(input logic [7:0] hdr, input logic [15:0] idx,
                                output int d, output int e, output int t, output int w);
        logic ok;
        logic [15:0] base, len;
        model_lookup(idx, ok, base, len);
        d = 0; e = 0; t = 0; w = 0;
        if (hdr != 8'h52 && hdr != 8'h57) e = 1;
        else if (!ok) e = 1;
        else if (len == 0) d = 1;
        else begin
            d = 1;
            if (hdr == 8'h52) t = int'(len);
            else w = int'(len);
        end
    endtask

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk);
        #1;
        rx_data = b;
        rx_rdy = 1'b1;
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
        rx_data = 8'h00;
        repeat (gap) @(posedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int w;
        for (w = 0; w < 3000; w++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check({tag, " idle"}, 64'(w < 3000), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_txn(input string tag, input logic [7:0] hdr,
                           input logic [15:0] idx, input logic [7:0] wseed,
                           input int e_done, input int e_err,
                           input int e_tx, input int e_we);
        int s_tx, s_we, s_done, s_err, bad, ntx, nwe;
        logic ok, is_rw;
        logic [15:0] base, len;
        s_tx = tx_q.size();
        s_we = wa_q.size();
        s_done = n_done;
        s_err = n_err;
        model_lookup(idx, ok, base, len);
        is_rw = (hdr == 8'h52) || (hdr == 8'h57);
        send_byte(hdr, $urandom_range(0, 2));
        if (is_rw) begin
            send_byte(idx[15:8], $urandom_range(0, 2));
            send_byte(idx[7:0], $urandom_range(0, 2));
            if (hdr == 8'h57 && ok)
                for (int k = 0; k < int'(len); k++)
                    send_byte(8'(k) + wseed, $urandom_range(0, 2));
        end
        wait_idle(tag);
        ntx = tx_q.size() - s_tx;
        nwe = wa_q.size() - s_we;
        check({tag, " done"}, 64'(n_done - s_done), 64'(e_done));
        check({tag, " err"}, 64'(n_err - s_err), 64'(e_err));
        check({tag, " ntx"}, 64'(ntx), 64'(e_tx));
        check({tag, " nwe"}, 64'(nwe), 64'(e_we));
        if (is_rw)
            check({tag, " idx"}, 64'(file_idx), 64'(idx));
        bad = 0;
        for (int k = 0; k < ntx && k < e_tx; k++)
            if (tx_q[s_tx+k] !== model_rd(base + 16'(k)))
                bad++;
        for (int k = 0; k < nwe && k < e_we; k++)
            if (wa_q[s_we+k] !== base + 16'(k) ||
                wd_q[s_we+k] !== 8'(k) + wseed)
                bad++;
        check({tag, " data"}, 64'(bad), 64'd0);
        if (hdr == 8'h57 && ok)
            for (int k = 0; k < int'(len); k++)
                exp_mem[base + 16'(k)] = 8'(k) + wseed;
    endtask

    typedef struct {
        logic [7:0]  hdr;
        logic [15:0] idx;
        logic [7:0]  wseed;
        int          e_done, e_err, e_tx, e_we;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int s_tx, s_we, s_done, s_err, w, bad;
        int d, e, t, wc;
        logic [7:0] hdr;
        logic [15:0] idx;

        reset = 1'b1;
        rx_rdy = 1'b0;
        rx_data = 8'h00;

        tbl_idx[0] = 16'h0001; tbl_base[0] = 16'd784;   tbl_len[0] = 16'd25; tbl_ok[0] = 1;
        tbl_idx[1] = 16'h0961; tbl_base[1] = 16'd809;   tbl_len[1] = 16'd49; tbl_ok[1] = 1;
        tbl_idx[2] = 16'h0FFF; tbl_base[2] = 16'd50;    tbl_len[2] = 16'd5;  tbl_ok[2] = 0;
        tbl_idx[3] = 16'h0002; tbl_base[3] = 16'd100;   tbl_len[3] = 16'd0;  tbl_ok[3] = 1;
        tbl_idx[4] = 16'h0003; tbl_base[4] = 16'hFFFC;  tbl_len[4] = 16'd8;  tbl_ok[4] = 1;
        tbl_idx[5] = 16'h0004; tbl_base[5] = 16'hFFFE;  tbl_len[5] = 16'd4;  tbl_ok[5] = 1;
        tbl_idx[6] = 16'h0005; tbl_base[6] = 16'd2000;  tbl_len[6] = 16'd2;  tbl_ok[6] = 1;
        tbl_idx[7] = 16'h1234; tbl_base[7] = 16'd3000;  tbl_len[7] = 16'd6;  tbl_ok[7] = 1;
        for (int i = 8; i < 12; i++) begin
            tbl_idx[i]  = 16'h2000 + 16'(i);
            tbl_base[i] = 16'($urandom_range(0, 65535));
            tbl_len[i]  = 16'($urandom_range(1, 30));
            tbl_ok[i]   = (i == 11) ? 1'($urandom_range(0, 1)) : 1'b1;
        end

        //          hdr     idx       seed   done err tx  we
        vecs[0]  = '{8'h52, 16'h0001, 8'h00, 1, 0, 25, 0};
        vecs[1]  = '{8'h57, 16'h0961, 8'h00, 1, 0, 0, 49};
        vecs[2]  = '{8'h41, 16'h0000, 8'h00, 0, 1, 0, 0};
        vecs[3]  = '{8'h52, 16'h0001, 8'h00, 1, 0, 25, 0};
        vecs[4]  = '{8'h52, 16'h0FFF, 8'h00, 0, 1, 0, 0};
        vecs[5]  = '{8'h57, 16'h0FFF, 8'h00, 0, 1, 0, 0};
        vecs[6]  = '{8'h52, 16'h0002, 8'h00, 1, 0, 0, 0};
        vecs[7]  = '{8'h57, 16'h0002, 8'h00, 1, 0, 0, 0};
        vecs[8]  = '{8'h52, 16'h0003, 8'h00, 1, 0, 8, 0};
        vecs[9]  = '{8'h57, 16'h0004, 8'hA0, 1, 0, 0, 4};
        vecs[10] = '{8'h52, 16'h0004, 8'h00, 1, 0, 4, 0};
        vecs[11] = '{8'h52, 16'h0961, 8'h00, 1, 0, 49, 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({tx_en, tx_data, mem_we, mem_wdata, mem_addr,
                   busy, done, err, file_idx}), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 64'({busy, done, err, tx_en, mem_we}), 64'd0);

        for (int i = 0; i < 12; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].hdr, vecs[i].idx,
                    vecs[i].wseed, vecs[i].e_done, vecs[i].e_err,
                    vecs[i].e_tx, vecs[i].e_we);

        // reset partway through a read
        s_tx = tx_q.size();
        s_done = n_done;
        s_err = n_err;
        send_byte(8'h52, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        for (w = 0; w < 3000; w++) begin
            @(negedge clk);
            if (tx_q.size() - s_tx >= 10) break;
        end
        check("rst_mid_reach", 64'(w < 3000), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_zero",
              64'({tx_en, tx_data, mem_we, mem_wdata, mem_addr,
                   busy, done, err, file_idx}), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ntx", 64'(tx_q.size() - s_tx), 64'd10);
        check("rst_mid_nodone", 64'(n_done - s_done), 64'd0);
        check("rst_mid_noerr", 64'(n_err - s_err), 64'd0);
        run_txn("rst_restart", 8'h52, 16'h0001, 8'h00, 1, 0, 25, 0);

        // header arriving in the same cycle as the write done pulse
        s_tx = tx_q.size();
        s_we = wa_q.size();
        s_done = n_done;
        send_byte(8'h57, 0);
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        @(posedge clk);
        #1 rx_data = 8'h11;
        rx_rdy = 1'b1;
        @(posedge clk);
        #1 rx_data = 8'h22;
        @(posedge clk);
        #1 rx_data = 8'h52;
        @(negedge clk);
        check("coll_done_cycle", 64'(done), 64'd1);
        @(posedge clk);
        #1 rx_rdy = 1'b0;
        rx_data = 8'h00;
        @(negedge clk);
        check("coll_hdr_taken", 64'(busy), 64'd1);
        exp_mem[16'd2000] = 8'h11;
        exp_mem[16'd2001] = 8'h22;
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        wait_idle("coll");
        check("coll_nwe", 64'(wa_q.size() - s_we), 64'd2);
        check("coll_ntx", 64'(tx_q.size() - s_tx), 64'd2);
        check("coll_done", 64'(n_done - s_done), 64'd2);
        bad = 0;
        for (int k = 0; k < tx_q.size() - s_tx && k < 2; k++)
            if (tx_q[s_tx+k] !== model_rd(16'd2000 + 16'(k)))
                bad++;
        check("coll_data", 64'(bad), 64'd0);

        // initiator goes quiet partway through a write
        s_we = wa_q.size();
        s_done = n_done;
        s_err = n_err;
        send_byte(8'h57, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h31, 0);
        send_byte(8'h32, 0);
        send_byte(8'h33, 0);
        exp_mem[16'd3000] = 8'h31;
        exp_mem[16'd3001] = 8'h32;
        exp_mem[16'd3002] = 8'h33;
`ifdef RESP_TIMEOUT_EN
        for (w = 1; w <= 200; w++) begin
            @(negedge clk);
            if (err) break;
        end
        check("timeout_at", 64'(w), 64'd101);
        repeat (2) @(negedge clk);
        check("timeout_err", 64'(n_err - s_err), 64'd1);
        check("timeout_idle", 64'(busy), 64'd0);
        check("timeout_nwe", 64'(wa_q.size() - s_we), 64'd3);
        check("timeout_nodone", 64'(n_done - s_done), 64'd0);
`else
        repeat (150) @(negedge clk);
        check("silence_busy", 64'(busy), 64'd1);
        check("silence_noerr", 64'(n_err - s_err), 64'd0);
        send_byte(8'h34, 0);
        send_byte(8'h35, 1);
        send_byte(8'h36, 0);
        exp_mem[16'd3003] = 8'h34;
        exp_mem[16'd3004] = 8'h35;
        exp_mem[16'd3005] = 8'h36;
        wait_idle("silence");
        check("silence_nwe", 64'(wa_q.size() - s_we), 64'd6);
        check("silence_done", 64'(n_done - s_done), 64'd1);
`endif
        run_txn("readback_1234", 8'h52, 16'h1234, 8'h00, 1, 0,
`ifdef RESP_TIMEOUT_EN
                6, 0);
`else
                6, 0);
`endif

        // random transfers against the model
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                hdr = 8'($urandom_range(0, 255));
                if (hdr == 8'h52 || hdr == 8'h57)
                    hdr = 8'h00;
                idx = 16'h0000;
            end else begin
                hdr = $urandom_range(0, 1) ? 8'h52 : 8'h57;
                idx = 16'h2000 + 16'($urandom_range(8, 11));
            end
            model_expect(hdr, idx, d, e, t, wc);
            run_txn($sformatf("rnd%0d", it), hdr, idx,
                    8'($urandom_range(0, 255)), d, e, t, wc);
        end

        check("tx_en_while_busy", 64'(busy_viol), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
